uio_bus_responder: RTL and testbench

//   Register-file responder behind the TinyTapeout user pins. The bench or host
//   MCU initiates 4-phase req/ack transfers: command on ui_in, data on uio.

---
 rtl/uio_bus_responder.sv | 188 ++++++++++++++++++
 tb/tb_uio_bus_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uio_bus_responder.sv
// Register-file responder on the TinyTapeout user pins.
// The host runs 4-phase req/ack transfers. The command arrives on ui_in and the data on uio.
// Reads turn the uio bus around by raising uio_oe before ack.
module uio_bus_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter int         TURNAROUND  = 1,
    parameter logic [7:0] ID_VALUE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        TURN,
        ACK
    } state_t;

    localparam int              TURN_W    = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);
    localparam int              NUM_RW    = 14;

    state_t                   state;
    state_t                   state_next;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     req_s;
    logic                     req_armed;
    logic [TURN_W-1:0]        turn_cnt;
    logic [7:0]               reg_file [0:NUM_RW-1];
    logic [7:0]               txn_cnt;
    logic [7:0]               rd_data;
    logic [7:0]               uio_out_q;
    logic                     oe_q;
    logic                     ack_q;
    logic                     wr;
    logic [3:0]               addr;
    logic                     do_write;
    logic                     do_read;
    logic                     enter_ack;
    logic                     do_done;
    logic                     unused_bits;

    assign wr          = ui_in[1];
    assign addr        = ui_in[5:2];
    assign req_s       = sync_q[SYNC_STAGES-1];
    assign unused_bits = ^ui_in[7:6];

    // Bring the asynchronous host request into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ui_in[0]};
        end
    end

    // Hold the state register, the turnaround counter and the re-arm flag. A new transfer needs req_s to be seen low first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            turn_cnt  <= '0;
            req_armed <= 1'b0;
        end else begin
            state <= state_next;
            if (state == TURN) begin
                turn_cnt <= turn_cnt + TURN_W'(1);
            end else begin
                turn_cnt <= '0;
            end
            if (state == IDLE && state_next == CMD) begin
                req_armed <= 1'b0;
            end else if (!req_s) begin
                req_armed <= 1'b1;
            end
        end
    end

    // Compute the next state and the datapath strobes. Dropping ena cancels everything and returns to idle.
    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        do_read    = 1'b0;
        enter_ack  = 1'b0;
        do_done    = 1'b0;
        case (state)
            IDLE: begin
                if (req_s && req_armed) begin
                    state_next = CMD;
                end
            end
            CMD: begin
                if (wr) begin
                    do_write   = 1'b1;
                    enter_ack  = 1'b1;
                    state_next = ACK;
                end else begin
                    do_read    = 1'b1;
                    state_next = TURN;
                end
            end
            TURN: begin
                if (turn_cnt == TURN_LAST) begin
                    enter_ack  = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    do_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!ena) begin
            state_next = IDLE;
            do_write   = 1'b0;
            do_read    = 1'b0;
            enter_ack  = 1'b0;
            do_done    = 1'b0;
        end
    end

    // Select the read source. Address 14 returns the transfer counter and address 15 returns the fixed ID.
    always_comb begin
        rd_data = 8'h00;
        if (addr == 4'd15) begin
            rd_data = ID_VALUE;
        end else if (addr == 4'd14) begin
            rd_data = txn_cnt;
        end else begin
            rd_data = reg_file[addr];
        end
    end

    // Update the register file. Writes to the read-only addresses are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RW; i++) begin
                reg_file[i] <= 8'h00;
            end
        end else if (do_write && addr < 4'd14) begin
            reg_file[addr] <= uio_in;
        end
    end

    // Drive the handshake, the bus direction, the read data and the transfer counter.
    // uio_out keeps the last read value after oe falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uio_out_q <= 8'h00;
            oe_q      <= 1'b0;
            ack_q     <= 1'b0;
            txn_cnt   <= 8'h00;
        end else begin
            if (do_read) begin
                uio_out_q <= rd_data;
                oe_q      <= 1'b1;
            end
            if (enter_ack) begin
                ack_q <= 1'b1;
            end
            if (do_done) begin
                ack_q   <= 1'b0;
                oe_q    <= 1'b0;
                txn_cnt <= txn_cnt + 8'd1;
            end
            if (!ena) begin
                ack_q <= 1'b0;
                oe_q  <= 1'b0;
            end
        end
    end

    assign uio_out = uio_out_q;
    assign uio_oe  = {8{oe_q}};
    assign uo_out  = {reg_file[0][5:0], (state != IDLE), ack_q};

endmodule

// File: tb/tb_uio_bus_responder.sv
// Directed bench for uio_bus_responder.
// A register model pushes the expected read data into a queue, and each read pops it when ack rises.
module tb_uio_bus_responder;

    localparam int         SYNC_STAGES = 2;
    localparam int         TURNAROUND  = 1;
    localparam logic [7:0] ID_VALUE    = 8'hA5;
    localparam int         LAT_WR      = SYNC_STAGES + 2;
    localparam int         LAT_RD      = SYNC_STAGES + 2 + TURNAROUND;
    localparam int         LAT_REL     = SYNC_STAGES + 1;
    localparam int         BUDGET      = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    int         check_count = 0;
    int         pass_count  = 0;
    int         fail_count  = 0;

    logic [7:0] model_regs [0:13];
    logic [7:0] model_cnt;
    logic [7:0] exp_q [$];

    uio_bus_responder #(
        .SYNC_STAGES (SYNC_STAGES),
        .TURNAROUND  (TURNAROUND),
        .ID_VALUE    (ID_VALUE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .uo_out  (uo_out)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard stop if the stimulus ever wedges
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) begin
            pass_count++;
        end else begin
            fail_count++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] modelRead(input logic [3:0] addr);
        if (addr == 4'd15) return ID_VALUE;
        if (addr == 4'd14) return model_cnt;
        return model_regs[addr];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 14; i++) model_regs[i] = 8'h00;
        model_cnt = 8'h00;
        exp_q.delete();
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        @(negedge clk);
    endtask

    // Wait (bounded) for ack to reach the given level, noting the first cycle oe was driven
    task automatic waitAck(input logic level, output int cycles, output bit got, output int oe_cyc);
        cycles = 0;
        got    = 1'b0;
        oe_cyc = -1;
        while (!got && cycles < BUDGET) begin
            @(posedge clk);
            #1;
            cycles++;
            if (uio_oe == 8'hFF && oe_cyc < 0) oe_cyc = cycles;
            if (uo_out[0] == level) got = 1'b1;
        end
    endtask

    // One complete 4-phase transfer: push the expectation, drive it, and check it when ack rises and falls.
    task automatic applyStimulus(input logic wr, input logic [3:0] addr, input logic [7:0] data);
        int         cyc;
        int         oe_cyc;
        bit         got;
        logic [7:0] exp_val;
        exp_val = 8'h00;
        if (!wr) begin
            exp_q.push_back(modelRead(addr));
        end else if (addr < 4'd14) begin
            model_regs[addr] = data;
        end
        @(negedge clk);
        ui_in  = {2'b00, addr, wr, 1'b1};
        uio_in = data;
        waitAck(1'b1, cyc, got, oe_cyc);
        checkOutput("ack_rise", 32'(got), 32'd1);
        if (wr) begin
            checkOutput("wr_latency", cyc, LAT_WR);
            checkOutput("wr_oe_idle", oe_cyc, -1);
        end else begin
            checkOutput("rd_latency", cyc, LAT_RD);
            checkOutput("rd_oe_lead", oe_cyc, cyc - TURNAROUND);
            exp_val = exp_q.pop_front();
            checkOutput("rd_data", 32'(uio_out), 32'(exp_val));
        end
        checkOutput("uo_reg0", 32'(uo_out[7:2]), 32'(model_regs[0][5:0]));
        @(negedge clk);
        ui_in[0] = 1'b0;
        waitAck(1'b0, cyc, got, oe_cyc);
        checkOutput("ack_fall", 32'(got), 32'd1);
        checkOutput("release_latency", cyc, LAT_REL);
        checkOutput("oe_release", 32'(uio_oe), 32'h0);
        checkOutput("idle_after", 32'(uo_out[1]), 32'h0);
        if (!wr) checkOutput("rd_hold", 32'(uio_out), 32'(exp_val));
        model_cnt = model_cnt + 8'd1;
    endtask

    initial begin
        int   cyc;
        int   oe_cyc;
        bit   got;
        logic       r_wr;
        logic [3:0] r_addr;
        logic [7:0] r_data;

        // 1: reset values while reset is held, then the ID register
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        modelReset();
        #12;
        checkOutput("rst_uo_out", 32'(uo_out), 32'h0);
        checkOutput("rst_uio_oe", 32'(uio_oe), 32'h0);
        checkOutput("rst_uio_out", 32'(uio_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 4'd15, 8'h00);
        checkOutput("t1_id", 32'(uio_out), 32'hA5);

        // 2: write then read back
        applyStimulus(1'b1, 4'd0, 8'h3C);
        applyStimulus(1'b0, 4'd0, 8'h00);
        checkOutput("t2_uo_reg0", 32'(uo_out[7:2]), 32'h3C);

        // 3: read turnaround on another address, plus the top read/write address
        applyStimulus(1'b1, 4'd5, 8'h5A);
        applyStimulus(1'b1, 4'd13, 8'hE7);
        applyStimulus(1'b0, 4'd5, 8'h00);
        applyStimulus(1'b0, 4'd13, 8'h00);

        // 4: read-only writes, then counter run-up and wrap from a clean reset
        applyStimulus(1'b1, 4'd15, 8'h00);
        applyStimulus(1'b0, 4'd15, 8'h00);
        checkOutput("t4_id_kept", 32'(uio_out), 32'hA5);
        applyStimulus(1'b1, 4'd14, 8'h77);
        applyStimulus(1'b0, 4'd14, 8'h00);
        resetDut();
        for (int i = 0; i < 255; i++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = 4'($urandom_range(0, 13));
            r_data = 8'($urandom);
            applyStimulus(r_wr, r_addr, r_data);
        end
        applyStimulus(1'b0, 4'd14, 8'h00);
        checkOutput("t4_cnt_ff", 32'(uio_out), 32'hFF);
        applyStimulus(1'b0, 4'd14, 8'h00);
        checkOutput("t4_cnt_wrap", 32'(uio_out), 32'h00);

        // 5: ena dropped during the ACK phase of a read
        applyStimulus(1'b1, 4'd3, 8'h96);
        @(negedge clk);
        ui_in = {2'b00, 4'd3, 1'b0, 1'b1};
        waitAck(1'b1, cyc, got, oe_cyc);
        checkOutput("t5_ack", 32'(got), 32'd1);
        checkOutput("t5_data", 32'(uio_out), 32'h96);
        @(negedge clk);
        ena = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t5_ack_drop", 32'(uo_out[0]), 32'h0);
        checkOutput("t5_oe_drop", 32'(uio_oe), 32'h0);
        checkOutput("t5_busy_drop", 32'(uo_out[1]), 32'h0);
        @(negedge clk);
        ena = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("t5_no_retrigger", 32'(uo_out[1]), 32'h0);
        ui_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 4'd14, 8'h00);
        applyStimulus(1'b0, 4'd3, 8'h00);

        // 6: asynchronous reset while in TURN
        applyStimulus(1'b1, 4'd0, 8'hC3);
        @(negedge clk);
        ui_in = {2'b00, 4'd0, 1'b0, 1'b1};
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < BUDGET) begin
            @(posedge clk);
            #1;
            cyc++;
            if (uio_oe == 8'hFF) got = 1'b1;
        end
        checkOutput("t6_turn_reached", 32'(got), 32'd1);
        checkOutput("t6_busy_turn", 32'(uo_out[1]), 32'h1);
        checkOutput("t6_ack_low_turn", 32'(uo_out[0]), 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_oe_async", 32'(uio_oe), 32'h0);
        checkOutput("t6_uo_async", 32'(uo_out), 32'h0);
        checkOutput("t6_uio_out_async", 32'(uio_out), 32'h0);
        ui_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        @(negedge clk);
        applyStimulus(1'b0, 4'd0, 8'h00);
        applyStimulus(1'b0, 4'd13, 8'h00);
        applyStimulus(1'b0, 4'd14, 8'h00);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
